// File: rtl/ysyx_23060187_pkg.sv
// Shared encodings for the memory arbiter: FSM states, transaction owner, store byte masks.
// Pure constants; no logic, no latency, no flow control.
package ysyx_23060187_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_REQ  = 2'd1;
  localparam arb_state_t ST_WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [7:0] WMASK_B = 8'h01;
  localparam logic [7:0] WMASK_H = 8'h03;
  localparam logic [7:0] WMASK_W = 8'h0F;

endpackage

// File: rtl/ysyx_23060187_arb_prio.sv
// LSU-priority grant with a saturating starvation counter that eventually forces IFU through.
// Grants are combinational (0 cycles) and only asserted while the arbiter is idle.
module ysyx_23060187_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             ifu_starved;

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    ifu_starved  = (starve_cnt_q >= LIMIT);
    grant_lsu    = idle && lsu_valid && !(ifu_valid && ifu_starved);
    grant_ifu    = idle && ifu_valid && !grant_lsu;
    starve_cnt_d = starve_cnt_q;
    // Counts only LSU wins that actually held off a waiting IFU.
    if (grant_ifu) begin
      starve_cnt_d = '0;
    end else if (grant_lsu && ifu_valid && !ifu_starved) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060187_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight, LSU first with a starvation guard.
// Accept at N, mem_req_valid at N+1, response pulse >= N+2; readies drop while busy, REQ holds until mem_req_ready.
module ysyx_23060187_mem_arbiter
  import ysyx_23060187_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MASK_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proto_err
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              proto_err_q, proto_err_d;
  logic              arb_idle;
  logic              grant_ifu, grant_lsu;
  logic              resp_fire;

  // No handshakes while reset is held, even though the FSM is already IDLE.
  assign arb_idle = rst && (state_q == ST_IDLE);

  ysyx_23060187_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_prio (
    .clk      (clk),
    .rst      (rst),
    .idle     (arb_idle),
    .ifu_valid(ifu_req_valid),
    .lsu_valid(lsu_req_valid),
    .grant_ifu(grant_ifu),
    .grant_lsu(grant_lsu)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IFU;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    proto_err_d = proto_err_q || (mem_resp_valid && (state_q != ST_WAIT));
    case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          state_d = ST_REQ;
          owner_d = OWN_LSU;
          wen_d   = lsu_wen;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
        end else if (grant_ifu) begin
          state_d = ST_REQ;
          owner_d = OWN_IFU;
          wen_d   = 1'b0;
          addr_d  = ifu_addr;
          wdata_d = '0;
          wmask_d = '0;
        end
      end
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_resp_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resp_fire      = (state_q == ST_WAIT) && mem_resp_valid;
    ifu_req_ready  = grant_ifu;
    lsu_req_ready  = grant_lsu;
    mem_req_valid  = (state_q == ST_REQ);
    mem_wen        = wen_q;
    mem_addr       = addr_q;
    mem_wdata      = wdata_q;
    mem_wmask      = wmask_q;
    ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
    lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
    // Read data passes straight through, zeroed outside the owner's pulse and on store acks.
    ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    lsu_rdata      = (lsu_resp_valid && !wen_q) ? mem_rdata : '0;
    proto_err      = proto_err_q;
  end

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: directed scenarios plus a randomized run
// against a transaction-level model of arbitration, latency and a byte-masked memory.
module tb_ysyx_23060187_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [logic [31:0]];

  always #5 clk = ~clk;

  ysyx_23060187_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  // Called in a REQ cycle: accept immediately, respond in the first WAIT cycle.
  task automatic finish_txn(input logic [31:0] rdata);
    mem_req_ready = 1;
    step;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = rdata;
    step;
    mem_resp_valid = 0;
    settle;
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_0F0F;
  endfunction

  function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
    logic [31:0] w;
    w = mem_read(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_model[a] = w;
  endfunction

  task automatic test_reset;
    logic [170:0] outs;
    rst = 0;
    clear_inputs;
    ifu_req_valid = 1; lsu_req_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    step;
    outs = {ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
            mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, proto_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected all zero", outs);
    end
    clear_inputs;
    rst = 1;
    step;
  endtask

  task automatic test_ifu_fetch;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    settle;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      errors++; $display("FAIL fetch_ready: got %b expected 10", {ifu_req_ready, lsu_req_ready});
    end
    step;
    ifu_req_valid = 0;
    settle;
    checks++;
    if ({mem_req_valid, mem_wen, mem_addr, mem_wmask, ifu_resp_valid} !== {1'b1, 1'b0, 32'h8000_0000, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL fetch_req: got v=%b wen=%b addr=%h mask=%h resp=%b expected 1 0 80000000 00 0",
               mem_req_valid, mem_wen, mem_addr, mem_wmask, ifu_resp_valid);
    end
    step;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    settle;
    checks++;
    if ({ifu_resp_valid, ifu_rdata, lsu_resp_valid, mem_req_valid} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fetch_resp: got ifu_v=%b rdata=%h lsu_v=%b req_v=%b expected 1 00000413 0 0",
               ifu_resp_valid, ifu_rdata, lsu_resp_valid, mem_req_valid);
    end
    step;
    mem_resp_valid = 0;
    settle;
    checks++;
    if (ifu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_single_pulse: got %b expected 0", ifu_resp_valid);
    end
  endtask

  task automatic test_priority;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0100; lsu_wmask = 8'h0F;
    settle;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      errors++; $display("FAIL prio_both_valid: got %b expected 01", {ifu_req_ready, lsu_req_ready});
    end
    step;
    lsu_req_valid = 0; mem_req_ready = 1;
    settle;
    checks++;
    if ({mem_req_valid, ifu_req_ready, mem_addr} !== {1'b1, 1'b0, 32'h8000_0100}) begin
      errors++;
      $display("FAIL prio_lsu_req: got v=%b ifu_rdy=%b addr=%h expected 1 0 80000100", mem_req_valid, ifu_req_ready, mem_addr);
    end
    step;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    settle;
    checks++;
    if ({lsu_resp_valid, lsu_rdata, ifu_resp_valid, ifu_req_ready} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prio_lsu_resp: got lsu_v=%b rdata=%h ifu_v=%b ifu_rdy=%b expected 1 12345678 0 0",
               lsu_resp_valid, lsu_rdata, ifu_resp_valid, ifu_req_ready);
    end
    step;
    mem_resp_valid = 0;
    settle;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      errors++; $display("FAIL prio_ifu_next: got %b expected 10", {ifu_req_ready, lsu_req_ready});
    end
    step;
    ifu_req_valid = 0;
    settle;
    checks++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0004}) begin
      errors++; $display("FAIL prio_ifu_req: got v=%b addr=%h expected 1 80000004", mem_req_valid, mem_addr);
    end
    finish_txn(32'h0000_0013);
  endtask

  task automatic test_starvation;
    logic [1:0] exp_rdy;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
    lsu_req_valid = 1; lsu_wen = 0; lsu_wmask = 8'h0F;
    for (int k = 0; k < 5; k++) begin
      lsu_addr = 32'h8000_0200 + 32'(k * 4);
      settle;
      exp_rdy = (k < 4) ? 2'b01 : 2'b10;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== exp_rdy) begin
        errors++; $display("FAIL starve_grant_%0d: got %b expected %b", k, {ifu_req_ready, lsu_req_ready}, exp_rdy);
      end
      step;
      if (k == 4) ifu_req_valid = 0;
      finish_txn(32'(k));
    end
    ifu_req_valid = 1; lsu_req_valid = 1;
    settle;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      errors++; $display("FAIL starve_cleared: got %b expected 01", {ifu_req_ready, lsu_req_ready});
    end
    step;
    ifu_req_valid = 0; lsu_req_valid = 0;
    finish_txn(32'h0);
  endtask

  task automatic test_store_stall;
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0010; lsu_wdata = 32'h0000_00AB; lsu_wmask = 8'h01;
    settle;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      errors++; $display("FAIL store_accept: got %b expected 1", lsu_req_ready);
    end
    step;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 8'hFF;
    mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++;
      if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h8000_0010, 32'h0000_00AB, 8'h01}) begin
        errors++;
        $display("FAIL store_stable_%0d: got v=%b wen=%b addr=%h wdata=%h mask=%h expected 1 1 80000010 000000ab 01",
                 i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
      end
      step;
    end
    mem_req_ready = 1;
    step;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
    settle;
    checks++;
    if ({lsu_resp_valid, lsu_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL store_ack: got v=%b rdata=%h expected 1 00000000", lsu_resp_valid, lsu_rdata);
    end
    step;
    mem_resp_valid = 0;
    settle;
  endtask

  task automatic test_reset_in_wait;
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0020; lsu_wmask = 8'h0F;
    step;
    lsu_req_valid = 0; mem_req_ready = 1;
    step;
    mem_req_ready = 0; rst = 0;
    step;
    rst = 1; mem_resp_valid = 1; mem_rdata = 32'h0000_0055;
    settle;
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin
      errors++;
      $display("FAIL wait_reset_no_resp: got ifu_v=%b lsu_v=%b req_v=%b expected 000", ifu_resp_valid, lsu_resp_valid, mem_req_valid);
    end
    step;
    mem_resp_valid = 0;
    settle;
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL wait_reset_proto_err: got %b expected 1", proto_err);
    end
  endtask

  task automatic test_random;
    int          wins = 0;
    int          phase = 0;
    int          delay = 0;
    logic        own_lsu = 0;
    logic        e_wen = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_word;
    logic [7:0]  e_mask = 0;
    logic        exp_ifu, exp_lsu, ifu_fire, lsu_fire;
    ifu_fire = 0; lsu_fire = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (ifu_fire || !ifu_req_valid) begin
        ifu_req_valid = ($urandom_range(0, 2) != 0);
        ifu_addr = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4);
      end else if ($urandom_range(0, 15) == 0) begin
        ifu_req_valid = 0;
      end
      if (lsu_fire || !lsu_req_valid) begin
        lsu_req_valid = ($urandom_range(0, 2) != 0);
        lsu_wen = $urandom_range(0, 1) == 1;
        lsu_addr = 32'h8000_0000 + 32'($urandom_range(0, 7) * 4);
        lsu_wdata = $urandom;
        case ($urandom_range(0, 2))
          0: lsu_wmask = 8'h01;
          1: lsu_wmask = 8'h03;
          default: lsu_wmask = 8'h0F;
        endcase
      end else if ($urandom_range(0, 15) == 0) begin
        lsu_req_valid = 0;
      end
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_resp_valid = (phase == 2) && (delay == 0);
      if (phase == 2 && delay > 0) delay--;
      e_word = mem_read(e_addr);
      mem_rdata = (mem_resp_valid && !e_wen) ? e_word : $urandom;
      settle;

      exp_lsu = (phase == 0) && lsu_req_valid && !(ifu_req_valid && wins >= 4);
      exp_ifu = (phase == 0) && ifu_req_valid && !exp_lsu;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu, exp_lsu}) begin
        errors++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, {ifu_req_ready, lsu_req_ready}, {exp_ifu, exp_lsu});
      end
      checks++;
      if (mem_req_valid !== (phase == 1)) begin
        errors++; $display("FAIL rand_req_valid c%0d: got %b expected %b", cyc, mem_req_valid, phase == 1);
      end
      if (phase == 1) begin
        checks++;
        if ({mem_wen, mem_addr, mem_wdata, mem_wmask} !== {e_wen, e_addr, e_wdata, e_mask}) begin
          errors++;
          $display("FAIL rand_req_fields c%0d: got %b %h %h %h expected %b %h %h %h", cyc,
                   mem_wen, mem_addr, mem_wdata, mem_wmask, e_wen, e_addr, e_wdata, e_mask);
        end
      end
      checks++;
      if ({ifu_resp_valid, lsu_resp_valid} !== {mem_resp_valid && !own_lsu, mem_resp_valid && own_lsu}) begin
        errors++;
        $display("FAIL rand_resp_valid c%0d: got %b expected %b", cyc, {ifu_resp_valid, lsu_resp_valid},
                 {mem_resp_valid && !own_lsu, mem_resp_valid && own_lsu});
      end
      if (mem_resp_valid) begin
        checks++;
        if (own_lsu && lsu_rdata !== (e_wen ? 32'h0 : e_word)) begin
          errors++; $display("FAIL rand_lsu_rdata c%0d: got %h expected %h", cyc, lsu_rdata, e_wen ? 32'h0 : e_word);
        end else if (!own_lsu && ifu_rdata !== e_word) begin
          errors++; $display("FAIL rand_ifu_rdata c%0d: got %h expected %h", cyc, ifu_rdata, e_word);
        end
      end
      checks++;
      if (proto_err !== 1'b0) begin
        errors++; $display("FAIL rand_proto_err c%0d: got %b expected 0", cyc, proto_err);
      end

      ifu_fire = exp_ifu; lsu_fire = exp_lsu;
      if (exp_lsu) begin
        phase = 1; own_lsu = 1;
        e_wen = lsu_wen; e_addr = lsu_addr; e_wdata = lsu_wdata; e_mask = lsu_wmask;
        if (ifu_req_valid && wins < 4) wins++;
      end else if (exp_ifu) begin
        phase = 1; own_lsu = 0;
        e_wen = 0; e_addr = ifu_addr; e_wdata = 0; e_mask = 0;
        wins = 0;
      end else if (phase == 1 && mem_req_ready) begin
        phase = 2;
        delay = $urandom_range(0, 2);
        if (e_wen) mem_write(e_addr, e_wdata, e_mask);
      end else if (phase == 2 && mem_resp_valid) begin
        phase = 0;
      end
      step;
    end
    clear_inputs;
  endtask

  initial begin
    rst = 0;
    clear_inputs;
    test_reset;
    test_ifu_fetch;
    test_priority;
    test_starvation;
    test_store_stall;
    test_reset_in_wait;
    test_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
